// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: a Moore FSM that sequences fetch, decode, execute,
// memory and writeback steps and drives every datapath select and write enable.
module mips_multicycle_ctrl #(
   parameter int OPCODE_WIDTH = 6,
   parameter int STATE_WIDTH  = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [OPCODE_WIDTH-1:0] opcode,
   input  logic                    zero,
   input  logic                    mem_ready,
   output logic                    pc_write,
   output logic                    pc_write_cond,
   output logic                    i_or_d,
   output logic                    mem_read,
   output logic                    mem_write,
   output logic                    ir_write,
   output logic [1:0]              mem_to_reg,
   output logic [1:0]              reg_dst,
   output logic                    reg_write,
   output logic                    alu_src_a,
   output logic [1:0]              alu_src_b,
   output logic [1:0]              alu_op,
   output logic [1:0]              pc_source,
   output logic                    illegal_op,
   output logic [STATE_WIDTH-1:0]  state
);

   typedef enum logic [STATE_WIDTH-1:0] {
      FETCH    = STATE_WIDTH'(0),
      DECODE   = STATE_WIDTH'(1),
      MEMADR   = STATE_WIDTH'(2),
      MEMRD    = STATE_WIDTH'(3),
      MEMWB    = STATE_WIDTH'(4),
      MEMWR    = STATE_WIDTH'(5),
      RTYPE_EX = STATE_WIDTH'(6),
      RTYPE_WB = STATE_WIDTH'(7),
      BEQ      = STATE_WIDTH'(8),
      JUMP     = STATE_WIDTH'(9),
      JAL      = STATE_WIDTH'(10),
      ADDI_EX  = STATE_WIDTH'(11),
      ADDI_WB  = STATE_WIDTH'(12)
   } state_t;

   localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = OPCODE_WIDTH'(6'h00);
   localparam logic [OPCODE_WIDTH-1:0] OP_J     = OPCODE_WIDTH'(6'h02);
   localparam logic [OPCODE_WIDTH-1:0] OP_JAL   = OPCODE_WIDTH'(6'h03);
   localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = OPCODE_WIDTH'(6'h04);
   localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = OPCODE_WIDTH'(6'h08);
   localparam logic [OPCODE_WIDTH-1:0] OP_LW    = OPCODE_WIDTH'(6'h23);
   localparam logic [OPCODE_WIDTH-1:0] OP_SW    = OPCODE_WIDTH'(6'h2B);

   state_t state_q, state_d;
   logic   opcode_legal;

   // The branch decision is made in the datapath (pc_write_cond AND zero), so zero is not consumed here.
   logic unused_zero;
   assign unused_zero = zero;

   always_comb begin
      opcode_legal = 1'b0;
      case (opcode)
         OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_ADDI, OP_LW, OP_SW: opcode_legal = 1'b1;
         default:                                               opcode_legal = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH:    if (mem_ready) state_d = DECODE;
         DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYPE:     state_d = RTYPE_EX;
               OP_BEQ:       state_d = BEQ;
               OP_J:         state_d = JUMP;
               OP_JAL:       state_d = JAL;
               OP_ADDI:      state_d = ADDI_EX;
               default:      state_d = FETCH;
            endcase
         end
         MEMADR:   state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
         MEMRD:    if (mem_ready) state_d = MEMWB;
         MEMWB:    state_d = FETCH;
         MEMWR:    if (mem_ready) state_d = FETCH;
         RTYPE_EX: state_d = RTYPE_WB;
         RTYPE_WB: state_d = FETCH;
         BEQ:      state_d = FETCH;
         JUMP:     state_d = FETCH;
         JAL:      state_d = FETCH;
         ADDI_EX:  state_d = ADDI_WB;
         ADDI_WB:  state_d = FETCH;
         default:  state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= FETCH;
      else       state_q <= state_d;
   end

   // Outputs are forced low while reset is held, even though the register already reads FETCH.
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 2'd0;
      reg_dst       = 2'd0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'd0;
      alu_op        = 2'd0;
      pc_source     = 2'd0;
      illegal_op    = 1'b0;
      if (!reset) begin
         case (state_q)
            FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = 2'd1;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
            end
            DECODE: begin
               alu_src_b  = 2'd3;
               illegal_op = ~opcode_legal;
            end
            MEMADR: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'd2;
            end
            MEMRD: begin
               mem_read = 1'b1;
               i_or_d   = 1'b1;
            end
            MEMWB: begin
               reg_write  = 1'b1;
               mem_to_reg = 2'd1;
            end
            MEMWR: begin
               mem_write = 1'b1;
               i_or_d    = 1'b1;
            end
            RTYPE_EX: begin
               alu_src_a = 1'b1;
               alu_op    = 2'd2;
            end
            RTYPE_WB: begin
               reg_write = 1'b1;
               reg_dst   = 2'd1;
            end
            BEQ: begin
               alu_src_a     = 1'b1;
               alu_op        = 2'd1;
               pc_write_cond = 1'b1;
               pc_source     = 2'd1;
            end
            JUMP: begin
               pc_write  = 1'b1;
               pc_source = 2'd2;
            end
            JAL: begin
               pc_write   = 1'b1;
               pc_source  = 2'd2;
               reg_write  = 1'b1;
               reg_dst    = 2'd2;
               mem_to_reg = 2'd2;
            end
            ADDI_EX: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'd2;
            end
            ADDI_WB:  reg_write = 1'b1;
            default: ;
         endcase
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized bench for mips_multicycle_ctrl: an instruction-route model predicts the
// state sequence and a per-state output table predicts every control signal.
module tb_mips_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic [1:0] mem_to_reg, reg_dst, alu_src_b, alu_op, pc_source;
   logic       reg_write, alu_src_a, illegal_op;
   logic [3:0] state;

   mips_multicycle_ctrl #(.OPCODE_WIDTH(6), .STATE_WIDTH(4)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_source(pc_source), .illegal_op(illegal_op), .state(state)
   );

   always #5 clk = ~clk;

   logic [18:0] obs_vec;
   assign obs_vec = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                     mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                     pc_source, illegal_op};

   int num_checks = 0;
   int num_pass   = 0;

   // Each instruction class walks a fixed list of states; FETCH, MEMRD and MEMWR wait on mem_ready.
   int routes[8][5];
   int route_len[8];
   int model_idx;
   int model_cls;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      num_checks++;
      if (observed === expected) num_pass++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
   endtask

   function automatic int classify(input logic [5:0] op);
      case (op)
         6'h23:   return 0;
         6'h2B:   return 1;
         6'h00:   return 2;
         6'h04:   return 3;
         6'h02:   return 4;
         6'h03:   return 5;
         6'h08:   return 6;
         default: return 7;
      endcase
   endfunction

   function automatic logic [18:0] expVec(input int st, input logic mr, input logic ill);
      logic pw, pwc, iod, mrd, mwr, irw, rw, asa, io;
      logic [1:0] m2r, rd, asb, aop, pcs;
      {pw, pwc, iod, mrd, mwr, irw, rw, asa, io} = '0;
      {m2r, rd, asb, aop, pcs} = '0;
      case (st)
         0:  begin mrd = 1; asb = 1; irw = mr; pw = mr; end
         1:  begin asb = 3; io = ill; end
         2:  begin asa = 1; asb = 2; end
         3:  begin mrd = 1; iod = 1; end
         4:  begin rw = 1; m2r = 1; end
         5:  begin mwr = 1; iod = 1; end
         6:  begin asa = 1; aop = 2; end
         7:  begin rw = 1; rd = 1; end
         8:  begin asa = 1; aop = 1; pwc = 1; pcs = 1; end
         9:  begin pw = 1; pcs = 2; end
         10: begin pw = 1; pcs = 2; rw = 1; rd = 2; m2r = 2; end
         11: begin asa = 1; asb = 2; end
         12: rw = 1;
         default: ;
      endcase
      return {pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, asa, asb, aop, pcs, io};
   endfunction

   task automatic driveAndCheck(input logic [5:0] op, input logic mr, input logic z);
      int exp_state;
      opcode = op; mem_ready = mr; zero = z;
      #1;
      if (model_idx == 1) model_cls = classify(op);
      exp_state = (model_idx == 0) ? 0 : routes[model_cls][model_idx];
      checkOutput("state", 32'(state), 32'(exp_state));
      checkOutput("outputs", 32'(obs_vec), 32'(expVec(exp_state, mr, exp_state == 1 && model_cls == 7)));
      checkOutput("rw_mw_excl", 32'(reg_write & mem_write), 32'd0);
      checkOutput("reg_dst_ne3", 32'(reg_dst == 2'd3), 32'd0);
      if (!((exp_state == 0 || exp_state == 3 || exp_state == 5) && !mr)) begin
         model_idx++;
         if (model_idx == route_len[model_cls]) model_idx = 0;
      end
   endtask

   task automatic applyStimulus(input logic [5:0] op, input logic mr, input logic z);
      @(negedge clk);
      driveAndCheck(op, mr, z);
   endtask

   initial begin
      logic [5:0] op;
      logic       mr;
      routes[0] = '{0, 1, 2, 3, 4};   route_len[0] = 5;
      routes[1] = '{0, 1, 2, 5, 0};   route_len[1] = 4;
      routes[2] = '{0, 1, 6, 7, 0};   route_len[2] = 4;
      routes[3] = '{0, 1, 8, 0, 0};   route_len[3] = 3;
      routes[4] = '{0, 1, 9, 0, 0};   route_len[4] = 3;
      routes[5] = '{0, 1, 10, 0, 0};  route_len[5] = 3;
      routes[6] = '{0, 1, 11, 12, 0}; route_len[6] = 4;
      routes[7] = '{0, 1, 0, 0, 0};   route_len[7] = 2;
      model_idx = 0; model_cls = 7;

      reset = 1'b1; opcode = 6'h00; mem_ready = 1'b1; zero = 1'b0;
      #2;
      checkOutput("reset_state", 32'(state), 32'd0);
      checkOutput("reset_outputs", 32'(obs_vec), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // R-type: 0,1,6,7 then back to FETCH
      driveAndCheck(6'h00, 1'b1, 1'b0);
      repeat (3) applyStimulus(6'h00, 1'b1, 1'b0);

      // lw with three stall cycles in MEMRD
      repeat (3) applyStimulus(6'h23, 1'b1, 1'b0);
      repeat (3) applyStimulus(6'h23, 1'b0, 1'b0);
      repeat (2) applyStimulus(6'h23, 1'b1, 1'b0);

      // jal, beq with zero low and high, illegal 0x3F, sw with a stall
      repeat (3) applyStimulus(6'h03, 1'b1, 1'b0);
      repeat (3) applyStimulus(6'h04, 1'b1, 1'b0);
      repeat (3) applyStimulus(6'h04, 1'b1, 1'b1);
      repeat (2) applyStimulus(6'h3F, 1'b1, 1'b0);
      repeat (3) applyStimulus(6'h2B, 1'b1, 1'b0);
      applyStimulus(6'h2B, 1'b0, 1'b0);
      applyStimulus(6'h2B, 1'b1, 1'b0);

      // Asynchronous reset in the middle of a MEMRD stall
      repeat (3) applyStimulus(6'h23, 1'b1, 1'b0);
      applyStimulus(6'h23, 1'b0, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("async_rst_state", 32'(state), 32'd0);
      checkOutput("async_rst_outputs", 32'(obs_vec), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      model_idx = 0;
      driveAndCheck(6'h00, 1'b1, 1'b0);
      checkOutput("release_ir_write", 32'(ir_write), 32'd1);
      checkOutput("release_pc_write", 32'(pc_write), 32'd1);
      repeat (3) applyStimulus(6'h00, 1'b1, 1'b0);

      // Random instruction stream with random memory stalls
      op = 6'h00;
      for (int i = 0; i < 2000; i++) begin
         if (model_idx == 0) begin
            case ($urandom_range(0, 7))
               0: op = 6'h23;
               1: op = 6'h2B;
               2: op = 6'h00;
               3: op = 6'h04;
               4: op = 6'h02;
               5: op = 6'h03;
               6: op = 6'h08;
               default: begin
                  op = 6'($urandom_range(0, 63));
                  while (classify(op) != 7) op = 6'($urandom_range(0, 63));
               end
            endcase
         end
         mr = ($urandom_range(0, 3) != 0);
         applyStimulus(op, mr, 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", num_pass, num_checks);
      $finish;
   end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Moore FSM control unit for the multicycle MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback steps from the instruction opcode.
- Drives every datapath select and write enable, including the 2-bit register-destination select of the 3:1 write-register mux (0 = rt, 1 = rd, 2 = $ra / reg 31).
- Stalls in memory states until the memory interface reports ready.

Parameters:
- OPCODE_WIDTH, 6, width of the instruction opcode field.
- STATE_WIDTH, 4, width of the state register and the debug state output.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- opcode  input  OPCODE_WIDTH  IR[31:26], valid from DECODE onward.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory access completes this cycle.
- pc_write  output  1  unconditional PC load.
- pc_write_cond  output  1  PC load if zero=1.
- i_or_d  output  1  memory address: 0 = PC, 1 = ALUOut.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- ir_write  output  1  instruction register load.
- mem_to_reg  output  2  writeback data: 0 = ALUOut, 1 = MDR, 2 = PC.
- reg_dst  output  2  write-register select into the 3:1 mux: 0 = rt, 1 = rd, 2 = reg 31.
- reg_write  output  1  register file write enable.
- alu_src_a  output  1  ALU A: 0 = PC, 1 = rs.
- alu_src_b  output  2  ALU B: 0 = rt, 1 = const 4, 2 = signext, 3 = signext<<2.
- alu_op  output  2  ALU op: 0 = add, 1 = sub, 2 = decode funct.
- pc_source  output  2  PC input: 0 = ALU result, 1 = ALUOut, 2 = jump target.
- illegal_op  output  1  one-cycle pulse on an unsupported opcode.
- state  output  STATE_WIDTH  current state, for debug.

Behaviour:
- Reset: asynchronous and active-high. While reset=1:
  - state = FETCH (0);
  - every other output = 0, including the FETCH-state signals.
  - Deasserting reset mid-instruction abandons that instruction; the next cycle is FETCH.
- Moore outputs: decoded from the state register only. Exception: in FETCH, pc_write and ir_write are gated by mem_ready.
- Outputs not listed for a state are 0.
- State encoding and per-state outputs:
  - FETCH(0): mem_read=1, alu_src_b=1. If mem_ready: ir_write=1, pc_write=1, next = DECODE; else stay.
  - DECODE(1): alu_src_b=3. Next state by opcode:
    - 0x23 lw or 0x2B sw -> MEMADR
    - 0x00 R-type -> RTYPE_EX
    - 0x04 beq -> BEQ
    - 0x02 j -> JUMP
    - 0x03 jal -> JAL
    - 0x08 addi -> ADDI_EX
    - any other opcode -> FETCH, with illegal_op=1 during this DECODE cycle.
  - MEMADR(2): alu_src_a=1, alu_src_b=2. Next = MEMRD for lw, MEMWR for sw (opcode held stable by IR).
  - MEMRD(3): mem_read=1, i_or_d=1. Stay until mem_ready, then MEMWB.
  - MEMWB(4): reg_write=1, reg_dst=0, mem_to_reg=1. Next = FETCH.
  - MEMWR(5): mem_write=1, i_or_d=1. Stay until mem_ready, then FETCH. mem_write stays asserted for the whole stall.
  - RTYPE_EX(6): alu_src_a=1, alu_src_b=0, alu_op=2. Next = RTYPE_WB.
  - RTYPE_WB(7): reg_write=1, reg_dst=1, mem_to_reg=0. Next = FETCH.
  - BEQ(8): alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond=1, pc_source=1. Next = FETCH.
  - JUMP(9): pc_write=1, pc_source=2. Next = FETCH.
  - JAL(10): pc_write=1, pc_source=2, reg_write=1, reg_dst=2, mem_to_reg=2. Next = FETCH. The register file captures PC (already PC+4) on the same edge the PC loads the target.
  - ADDI_EX(11): alu_src_a=1, alu_src_b=2, alu_op=0. Next = ADDI_WB.
  - ADDI_WB(12): reg_write=1, reg_dst=0, mem_to_reg=0. Next = FETCH.
  - Encodings 13-15: unreachable. If entered, next = FETCH with all outputs 0.
- Latency with mem_ready held at 1, in cycles per instruction:
  - lw 5; sw 4; R-type 4; addi 4; beq 3; j 3; jal 3; illegal 2.
  - Each cycle mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- reg_dst = 3 is never driven.
- reg_write and mem_write are never asserted in the same cycle.

Test Plan:
- Reset mid-MEMRD: assert reset asynchronously (no clock edge needed) -> state = 0 and all outputs 0 immediately. Release reset with mem_ready=1 -> ir_write=1 and pc_write=1 on the first cycle.
- R-type (opcode 0x00), mem_ready=1: states 0,1,6,7,0 -> reg_dst=1 and reg_write=1 in cycle 4 only.
- lw (0x23) with mem_ready low for 3 cycles in MEMRD: states 0,1,2,3,3,3,3,4 -> mem_read=1 throughout MEMRD; reg_dst=0 and mem_to_reg=1 in MEMWB.
- jal (0x03): states 0,1,10 -> in cycle 3, reg_dst=2, mem_to_reg=2, reg_write=1, pc_write=1, pc_source=2.
- beq (0x04) with zero=0 and with zero=1: pc_write_cond=1 in BEQ in both cases, and pc_write=0 in that state.
- Illegal opcode 0x3F: states 0,1,0 -> illegal_op pulses exactly one cycle, in DECODE; no write enables are asserted.
